// File: rtl/voice_allocator.sv
// Voice allocator: maps MIDI note-on/off events onto a fixed pool of wave-generator slots.
// Optional VOICE_STEAL_EN: when defined, a note-on with no free slot steals the oldest voice.
`ifndef N_OSCILLATORS
`define N_OSCILLATORS 8
`endif

module voice_allocator #(
  parameter int N_VOICES = `N_OSCILLATORS,
  parameter int AGE_W    = 16,
  localparam int IDX_W   = (N_VOICES > 1) ? $clog2(N_VOICES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ev_valid,
  output logic                ev_ready,
  input  logic                ev_on,
  input  logic [6:0]          ev_key,
  input  logic [31:0]         ev_freq,
  input  logic [31:0]         ev_velocity,
  output logic                voice_we,
  output logic [IDX_W-1:0]    voice_idx,
  output logic [31:0]         voice_freq,
  output logic [31:0]         voice_velocity,
  output logic                voice_gate,
  output logic [N_VOICES-1:0] voice_active,
  output logic                ev_dropped
);
  typedef enum logic [1:0] {IDLE, LOOKUP, COMMIT} state_t;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  state_t              state_reg, state_next;
  logic                accept;
  logic                cap_on_reg;
  logic [6:0]          cap_key_reg;
  logic [31:0]         cap_freq_reg, cap_vel_reg;
  logic                we_reg, dropped_reg;
  logic [N_VOICES-1:0] active_reg;
  logic [6:0]          key_reg  [N_VOICES];
  logic [AGE_W-1:0]    age_reg  [N_VOICES];
  logic [31:0]         freq_mem [N_VOICES];
  logic [31:0]         vel_mem  [N_VOICES];
  logic [N_VOICES-1:0] match_vec;
  logic                hit, free, sel_valid;
  logic [IDX_W-1:0]    hit_idx, free_idx, sel_idx;
  logic                commit, commit_on;

  // Outputs are masked by rst so an event aborted in COMMIT never shows a strobe.
  assign ev_ready     = (state_reg == IDLE) && !rst;
  assign accept       = ev_valid && ev_ready;
  assign voice_we     = we_reg && !rst;
  assign ev_dropped   = dropped_reg && !rst;
  assign voice_active = active_reg;
  assign commit       = (state_reg == LOOKUP) && sel_valid;
  assign commit_on    = commit && cap_on_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = LOOKUP;
      LOOKUP:  state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < N_VOICES; gi++) begin : g_slot
      assign match_vec[gi] = active_reg[gi] && (key_reg[gi] == cap_key_reg);

      // Ages count note-ons since this slot was last (re)triggered.
      always_ff @(posedge clk) begin
        if (rst) begin
          key_reg[gi] <= '0;
          age_reg[gi] <= '0;
        end else if (commit_on) begin
          if (IDX_W'(gi) == sel_idx) begin
            key_reg[gi] <= cap_key_reg;
            age_reg[gi] <= '0;
          end else if (active_reg[gi] && age_reg[gi] != AGE_MAX) begin
            age_reg[gi] <= age_reg[gi] + 1'b1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = N_VOICES - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!active_reg[i]) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic [IDX_W-1:0] oldest_idx;
  logic [AGE_W-1:0] oldest_age;

  // Strict compare keeps the lowest index on equal ages.
  always_comb begin
    oldest_idx = '0;
    oldest_age = age_reg[0];
    for (int i = 1; i < N_VOICES; i++) begin
      if (age_reg[i] > oldest_age) begin
        oldest_age = age_reg[i];
        oldest_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    sel_valid = hit;
    sel_idx   = hit_idx;
    if (cap_on_reg && !hit) begin
      if (free) begin
        sel_valid = 1'b1;
        sel_idx   = free_idx;
      end
`ifdef VOICE_STEAL_EN
      else begin
        sel_valid = 1'b1;
        sel_idx   = oldest_idx;
      end
`endif
    end
  end

  // Per-slot field shadow, written on note-on and read back on note-off.
  always_ff @(posedge clk) begin
    if (commit_on && !rst) begin
      freq_mem[sel_idx] <= cap_freq_reg;
      vel_mem[sel_idx]  <= cap_vel_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_on_reg     <= 1'b0;
      cap_key_reg    <= '0;
      cap_freq_reg   <= '0;
      cap_vel_reg    <= '0;
      we_reg         <= 1'b0;
      dropped_reg    <= 1'b0;
      voice_idx      <= '0;
      voice_freq     <= '0;
      voice_velocity <= '0;
      voice_gate     <= 1'b0;
      active_reg     <= '0;
    end else begin
      we_reg      <= 1'b0;
      dropped_reg <= 1'b0;
      if (accept) begin
        cap_on_reg   <= ev_on;
        cap_key_reg  <= ev_key;
        cap_freq_reg <= ev_freq;
        cap_vel_reg  <= ev_velocity;
      end
      if (state_reg == LOOKUP) begin
        if (commit) begin
          we_reg     <= 1'b1;
          voice_idx  <= sel_idx;
          voice_gate <= cap_on_reg;
          if (cap_on_reg) begin
            voice_freq          <= cap_freq_reg;
            voice_velocity      <= cap_vel_reg;
            active_reg[sel_idx] <= 1'b1;
          end else begin
            voice_freq          <= freq_mem[sel_idx];
            voice_velocity      <= vel_mem[sel_idx];
            active_reg[sel_idx] <= 1'b0;
          end
        end else begin
          dropped_reg <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed testbench for voice_allocator (4 voices); expectations follow VOICE_STEAL_EN if defined.
module tb_voice_allocator;
  localparam int NV = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ev_valid = 1'b0;
  logic          ev_on = 1'b0;
  logic [6:0]    ev_key = '0;
  logic [31:0]   ev_freq = '0;
  logic [31:0]   ev_velocity = '0;
  logic          ev_ready, voice_we, voice_gate, ev_dropped;
  logic [1:0]    voice_idx;
  logic [31:0]   voice_freq, voice_velocity;
  logic [NV-1:0] voice_active;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  voice_allocator #(.N_VOICES(NV), .AGE_W(16)) dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
    .ev_key(ev_key), .ev_freq(ev_freq), .ev_velocity(ev_velocity), .voice_we(voice_we),
    .voice_idx(voice_idx), .voice_freq(voice_freq), .voice_velocity(voice_velocity),
    .voice_gate(voice_gate), .voice_active(voice_active), .ev_dropped(ev_dropped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fq(input logic [6:0] k);
    return {5'd0, k, 20'h0_0000};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    ev_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", ev_ready, 0);
    check("rst_we", voice_we, 0);
    check("rst_drop", ev_dropped, 0);
    check("rst_active", voice_active, 0);
    check("rst_idx", voice_idx, 0);
    check("rst_fv", {voice_freq, voice_velocity}, 0);
    check("rst_gate", voice_gate, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", ev_ready, 1);
    $display("reset done, cycle %0d", cyc);
  endtask

  // Called at a negedge; returns at the negedge of cycle T+3.
  task automatic send(input logic on, input logic [6:0] key, input logic [31:0] f,
                      input logic [31:0] v, input logic hold, input logic exp_we,
                      input logic [1:0] exp_idx, input logic [31:0] exp_f,
                      input logic [31:0] exp_v, output int acc_cyc);
    int waited = 0;
    ev_on = on;
    ev_key = key;
    ev_freq = f;
    ev_velocity = v;
    ev_valid = 1'b1;
    while (!ev_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    acc_cyc = cyc;
    if (!ev_ready) begin
      check("accept_timeout", ev_ready, 1);
      ev_valid = 1'b0;
      return;
    end
    @(posedge clk);
    acc_cyc = cyc;
    @(negedge clk);
    if (!hold) ev_valid = 1'b0;
    check("lookup_ready", ev_ready, 0);
    check("lookup_we", voice_we, 0);
    check("lookup_drop", ev_dropped, 0);
    @(negedge clk);
    check("commit_we", voice_we, exp_we);
    check("commit_drop", ev_dropped, !exp_we);
    if (exp_we) begin
      check("commit_idx", voice_idx, exp_idx);
      check("commit_gate", voice_gate, on);
      check("commit_freq", voice_freq, exp_f);
      check("commit_vel", voice_velocity, exp_v);
    end
    @(negedge clk);
    check("done_ready", ev_ready, 1);
    check("done_we", voice_we, 0);
    if (exp_we) check("hold_idx", voice_idx, exp_idx);
    $display("event on=%0d key=%0d acc_cyc=%0d we=%0d idx=%0d gate=%0d drop_exp=%0d",
             on, key, acc_cyc, exp_we, exp_idx, on, !exp_we);
  endtask

  initial begin
    int c0, c1, c2, cx;
    do_reset();

    // Single note-on from reset
    send(1, 60, 32'h0100_0000, 32'h7F, 0, 1, 0, 32'h0100_0000, 32'h7F, cx);
    check("first_active", voice_active, 4'b0001);

    // Back-to-back with ev_valid held, then note-off and slot reuse
    do_reset();
    send(1, 60, fq(60), 60, 1, 1, 0, fq(60), 60, c0);
    send(1, 62, fq(62), 62, 1, 1, 1, fq(62), 62, c1);
    send(1, 64, fq(64), 64, 0, 1, 2, fq(64), 64, c2);
    check("b2b_gap1", c1 - c0, 3);
    check("b2b_gap2", c2 - c1, 3);
    check("b2b_active", voice_active, 4'b0111);
    send(0, 62, 32'h0, 32'h0, 0, 1, 1, fq(62), 62, cx);
    check("off62_active", voice_active, 4'b0101);
    send(1, 65, fq(65), 65, 0, 1, 1, fq(65), 65, cx);
    check("on65_active", voice_active, 4'b0111);

    // Retrigger of an active key
    do_reset();
    send(1, 60, fq(60), 32'h10, 0, 1, 0, fq(60), 32'h10, cx);
    send(1, 60, fq(60), 32'h20, 0, 1, 0, fq(60), 32'h20, cx);
    check("retrig_active", voice_active, 4'b0001);

    // Note-off for a key never played
    send(0, 70, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, cx);
    check("off70_active", voice_active, 4'b0001);

    // Full pool
    do_reset();
    for (int k = 0; k < NV; k++)
      send(1, 7'(40 + k), fq(7'(40 + k)), 32'(k), 0, 1, 2'(k), fq(7'(40 + k)), 32'(k), cx);
    check("full_active", voice_active, 4'b1111);
`ifdef VOICE_STEAL_EN
    send(1, 100, fq(100), 32'h55, 0, 1, 0, fq(100), 32'h55, cx);
    send(1, 101, fq(101), 32'h56, 0, 1, 1, fq(101), 32'h56, cx);
    check("steal_active", voice_active, 4'b1111);
    send(0, 40, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, cx);
    check("stolen_off_active", voice_active, 4'b1111);
`else
    send(1, 100, fq(100), 32'h55, 0, 0, 0, 32'h0, 32'h0, cx);
    send(1, 101, fq(101), 32'h56, 0, 0, 0, 32'h0, 32'h0, cx);
    check("nosteal_active", voice_active, 4'b1111);
    send(0, 40, 32'h0, 32'h0, 0, 1, 0, fq(40), 32'h0, cx);
    check("off40_active", voice_active, 4'b1110);
`endif

    // Reset during LOOKUP aborts the event
    do_reset();
    ev_on = 1'b1;
    ev_key = 7'd50;
    ev_freq = fq(50);
    ev_velocity = 32'h5;
    ev_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_we", voice_we, 0);
    check("abort_drop", ev_dropped, 0);
    check("abort_active", voice_active, 0);
    check("abort_ready_in_rst", ev_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_we_after", voice_we, 0);
    check("abort_ready_after", ev_ready, 1);
    $display("abort during lookup, cycle %0d", cyc);
    send(1, 50, fq(50), 32'h5, 0, 1, 0, fq(50), 32'h5, cx);
    check("recover_active", voice_active, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
